// File: rtl/bsg_fifos_to_axil_pkg.sv
// Shared types for the FIFO-to-AXI-Lite master: FSM state encoding, AXI-Lite
// response codes and the packed single-channel AXI-Lite bus structures.
package bsg_fifos_to_axil_pkg;

    typedef enum logic [2:0] {
        E_IDLE,
        E_WR,
        E_WR_RESP,
        E_RD_ADDR,
        E_RD_DATA,
        E_RESP
    } fsm_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Master-to-slave half of a 32-bit AXI-Lite bus, MSB first
    typedef struct packed {
        logic [31:0] awaddr;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } bsg_axil_mosi_bus_s;

    // Slave-to-master half of a 32-bit AXI-Lite bus, MSB first
    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } bsg_axil_miso_bus_s;

    localparam int unsigned AXIL_MOSI_W = $bits(bsg_axil_mosi_bus_s);
    localparam int unsigned AXIL_MISO_W = $bits(bsg_axil_miso_bus_s);

    function automatic int unsigned bsg_axil_mosi_bus_width(input int unsigned num_ch);
        return num_ch * AXIL_MOSI_W;
    endfunction

    function automatic int unsigned bsg_axil_miso_bus_width(input int unsigned num_ch);
        return num_ch * AXIL_MISO_W;
    endfunction

endpackage

// File: rtl/bsg_fifos_to_axil_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module bsg_counter_sat_en #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    // Count enabled events until the counter reaches all-ones
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bsg_fifos_to_axil.sv
// AXI-Lite master: converts a valid/ready request stream into single-beat
// AXI-Lite reads and writes, one outstanding transaction, strictly in order.
module bsg_fifos_to_axil
    import bsg_fifos_to_axil_pkg::*;
#(
    parameter logic [31:0]  axil_base_addr_p  = 32'h0000_0000,
    parameter int unsigned  err_count_width_p = 16,
    localparam int unsigned axil_mosi_bus_width_lp = bsg_axil_mosi_bus_width(1),
    localparam int unsigned axil_miso_bus_width_lp = bsg_axil_miso_bus_width(1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    output logic [axil_mosi_bus_width_lp-1:0] m_axil_bus_o,
    input  logic [axil_miso_bus_width_lp-1:0] m_axil_bus_i,
    input  logic                              req_v_i,
    input  logic                              req_we_i,
    input  logic [31:0]                       req_addr_i,
    input  logic [31:0]                       req_data_i,
    input  logic [3:0]                        req_wstrb_i,
    output logic                              req_ready_o,
    output logic                              resp_v_o,
    output logic                              resp_we_o,
    output logic [31:0]                       resp_data_o,
    output logic [1:0]                        resp_code_o,
    input  logic                              resp_ready_i,
    output logic [err_count_width_p-1:0]      err_count_o
);

    fsm_state_e         r_state;
    fsm_state_e         w_state_n;

    bsg_axil_mosi_bus_s w_mosi;
    bsg_axil_miso_bus_s w_miso;

    logic               r_live;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [3:0]         r_wstrb;
    logic               r_we;
    logic               r_aw_done;
    logic               r_w_done;
    logic [31:0]        r_resp_data;
    logic [1:0]         r_resp_code;

    logic               w_accept;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_err_inc;

    assign w_miso       = m_axil_bus_i;
    assign m_axil_bus_o = w_mosi;

    // r_live keeps req_ready_o low while reset is held even though the FSM rests in E_IDLE
    assign req_ready_o  = r_live && (r_state == E_IDLE);
    assign w_accept     = req_v_i && req_ready_o;
    assign w_aw_hs      = w_mosi.awvalid && w_miso.awready;
    assign w_w_hs       = w_mosi.wvalid && w_miso.wready;

    assign resp_v_o     = (r_state == E_RESP);
    assign resp_we_o    = r_we;
    assign resp_data_o  = r_resp_data;
    assign resp_code_o  = r_resp_code;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= E_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state, AXI channel outputs and error-count enable
    always_comb begin
        w_state_n = r_state;
        w_mosi    = '0;
        w_err_inc = 1'b0;

        w_mosi.awaddr = r_addr;
        w_mosi.wdata  = r_data;
        w_mosi.wstrb  = r_wstrb;
        w_mosi.araddr = r_addr;

        case (r_state)
            E_IDLE: begin
                if (w_accept) begin
                    w_state_n = req_we_i ? E_WR : E_RD_ADDR;
                end
            end
            E_WR: begin
                w_mosi.awvalid = !r_aw_done;
                w_mosi.wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_n = E_WR_RESP;
                end
            end
            E_WR_RESP: begin
                w_mosi.bready = 1'b1;
                if (w_miso.bvalid) begin
                    w_state_n = E_RESP;
                    w_err_inc = (w_miso.bresp != RESP_OKAY);
                end
            end
            E_RD_ADDR: begin
                w_mosi.arvalid = 1'b1;
                if (w_miso.arready) begin
                    w_state_n = E_RD_DATA;
                end
            end
            E_RD_DATA: begin
                w_mosi.rready = 1'b1;
                if (w_miso.rvalid) begin
                    w_state_n = E_RESP;
                    w_err_inc = (w_miso.rresp != RESP_OKAY);
                end
            end
            E_RESP: begin
                if (resp_ready_i) begin
                    w_state_n = E_IDLE;
                end
            end
            default: begin
                w_state_n = E_IDLE;
            end
        endcase
    end

    // Request capture, write handshake flags and response capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_live      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wstrb     <= '0;
            r_we        <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_resp_data <= '0;
            r_resp_code <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                E_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= req_addr_i + axil_base_addr_p;
                        r_data    <= req_data_i;
                        r_wstrb   <= req_wstrb_i;
                        r_we      <= req_we_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                E_WR: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                end
                E_WR_RESP: begin
                    if (w_miso.bvalid) begin
                        r_resp_code <= w_miso.bresp;
                        r_resp_data <= '0;
                    end
                end
                E_RD_DATA: begin
                    if (w_miso.rvalid) begin
                        r_resp_code <= w_miso.rresp;
                        r_resp_data <= w_miso.rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    bsg_counter_sat_en #(
        .width_p (err_count_width_p)
    ) u_err_count (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (w_err_inc),
        .count_o   (err_count_o)
    );

endmodule

// File: tb/tb_bsg_fifos_to_axil.sv
// Directed bench for bsg_fifos_to_axil with a small programmable-latency
// AXI-Lite slave; all DUT sampling and driving happens on the falling edge.
module tb_bsg_fifos_to_axil;
    import bsg_fifos_to_axil_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [AXIL_MOSI_W-1:0] mosi_vec;
    logic [AXIL_MISO_W-1:0] miso_vec;
    logic                   req_v = 1'b0;
    logic                   req_we = 1'b0;
    logic [31:0]            req_addr = '0;
    logic [31:0]            req_data = '0;
    logic [3:0]             req_wstrb = '0;
    logic                   req_ready;
    logic                   resp_v;
    logic                   resp_we;
    logic [31:0]            resp_data;
    logic [1:0]             resp_code;
    logic                   resp_ready = 1'b0;
    logic [1:0]             err_count;

    bsg_axil_mosi_bus_s     mo;
    bsg_axil_miso_bus_s     mi = '0;

    assign mo       = mosi_vec;
    assign miso_vec = mi;

    bsg_fifos_to_axil #(
        .axil_base_addr_p  (32'h0000_1000),
        .err_count_width_p (2)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .m_axil_bus_o (mosi_vec),
        .m_axil_bus_i (miso_vec),
        .req_v_i      (req_v),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_wstrb_i  (req_wstrb),
        .req_ready_o  (req_ready),
        .resp_v_o     (resp_v),
        .resp_we_o    (resp_we),
        .resp_data_o  (resp_data),
        .resp_code_o  (resp_code),
        .resp_ready_i (resp_ready),
        .err_count_o  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave wait-state configuration, set by the stimulus
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    always @(negedge clk) begin
        if (mo.awvalid) begin mi.awready = (aw_cnt == aw_wait); aw_cnt++; end
        else begin mi.awready = 1'b0; aw_cnt = 0; end
        if (mo.wvalid) begin mi.wready = (w_cnt == w_wait); w_cnt++; end
        else begin mi.wready = 1'b0; w_cnt = 0; end
        if (mo.bready) begin mi.bvalid = (b_cnt == b_wait); mi.bresp = bresp_cfg; b_cnt++; end
        else begin mi.bvalid = 1'b0; b_cnt = 0; end
        if (mo.arvalid) begin mi.arready = (ar_cnt == ar_wait); ar_cnt++; end
        else begin mi.arready = 1'b0; ar_cnt = 0; end
        if (mo.rready) begin
            mi.rvalid = (r_cnt == r_wait); mi.rdata = rdata_cfg; mi.rresp = rresp_cfg; r_cnt++;
        end else begin
            mi.rvalid = 1'b0; r_cnt = 0;
        end
    end

    // Bus monitor
    int          n_aw = 0, n_w = 0, n_b = 0, n_bready = 0, n_arv = 0, n_ar_bad = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] exp_araddr = '0;

    always @(posedge clk) begin
        if (mo.awvalid && mi.awready) begin n_aw <= n_aw + 1; last_awaddr <= mo.awaddr; end
        if (mo.wvalid && mi.wready) begin
            n_w <= n_w + 1; last_wdata <= mo.wdata; last_wstrb <= mo.wstrb;
        end
        if (mo.bready && mi.bvalid) n_b <= n_b + 1;
        if (mo.bready) n_bready <= n_bready + 1;
        if (mo.arvalid) begin
            n_arv <= n_arv + 1;
            if (mo.araddr != exp_araddr) n_ar_bad <= n_ar_bad + 1;
        end
    end

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        req_v = 1'b1; req_we = we; req_addr = addr; req_data = data; req_wstrb = strb;
        for (int k = 0; k < 40; k++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        check_eq("req_accept", req_ready, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
        req_v = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        for (int k = 0; k < 80; k++) begin
            if (resp_v) break;
            @(negedge clk);
        end
        check_eq("resp_valid", resp_v, 1'b1);
        lat = cyc - acc_cyc;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    int lat;
    int s_aw, s_w, s_b, s_bready, s_arv, s_arbad;
    logic [1:0] err_codes [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [1:0] err_exp   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        // Reset state
        #3;
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_resp_v", resp_v, 1'b0);
        check_eq("rst_valids", {mo.awvalid, mo.wvalid, mo.bready, mo.arvalid, mo.rready}, 5'b0);
        check_eq("rst_err", err_count, 2'd0);
        check_eq("rst_addr", mo.awaddr, 32'h0);
        req_v = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_hold_ready", req_ready, 1'b0);
        check_eq("rst_hold_valids", {mo.awvalid, mo.arvalid}, 2'b0);
        req_v = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", req_ready, 1'b1);

        // Zero-wait write
        s_aw = n_aw; s_w = n_w; s_b = n_b;
        send_req(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
        wait_resp(lat);
        check_eq("wr0_lat", lat, 3);
        check_eq("wr0_aw_cnt", n_aw - s_aw, 1);
        check_eq("wr0_w_cnt", n_w - s_w, 1);
        check_eq("wr0_b_cnt", n_b - s_b, 1);
        check_eq("wr0_awaddr", last_awaddr, 32'h0000_1010);
        check_eq("wr0_wdata", last_wdata, 32'hCAFE_F00D);
        check_eq("wr0_wstrb", last_wstrb, 4'hF);
        check_eq("wr0_we", resp_we, 1'b1);
        check_eq("wr0_code", resp_code, 2'b00);
        check_eq("wr0_data", resp_data, 32'h0);
        take_resp();

        // Write with w accepted four cycles ahead of aw
        aw_wait = 4; w_wait = 0;
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_bready = n_bready;
        send_req(1'b1, 32'h14, 32'h0BAD_F00D, 4'h5);
        @(negedge clk);
        check_eq("wr1_wvalid_drop", mo.wvalid, 1'b0);
        check_eq("wr1_awvalid_hold", mo.awvalid, 1'b1);
        check_eq("wr1_awaddr_hold", mo.awaddr, 32'h0000_1014);
        wait_resp(lat);
        check_eq("wr1_lat", lat, 7);
        check_eq("wr1_aw_cnt", n_aw - s_aw, 1);
        check_eq("wr1_w_cnt", n_w - s_w, 1);
        check_eq("wr1_bready_cyc", n_bready - s_bready, 1);
        check_eq("wr1_b_cnt", n_b - s_b, 1);
        check_eq("wr1_code", resp_code, 2'b00);
        take_resp();
        aw_wait = 0;

        // Read with arready after 2 waits, rvalid after 5 waits
        ar_wait = 2; r_wait = 5; rdata_cfg = 32'h0000_0003; rresp_cfg = 2'b00;
        exp_araddr = 32'h0000_101C;
        s_arv = n_arv; s_arbad = n_ar_bad;
        send_req(1'b0, 32'h1C, 32'hFFFF_FFFF, 4'hF);
        wait_resp(lat);
        check_eq("rd0_lat", lat, 10);
        check_eq("rd0_arvalid_cyc", n_arv - s_arv, 3);
        check_eq("rd0_araddr_stable", n_ar_bad - s_arbad, 0);
        check_eq("rd0_data", resp_data, 32'h0000_0003);
        check_eq("rd0_we", resp_we, 1'b0);
        check_eq("rd0_code", resp_code, 2'b00);
        check_eq("rd0_err", err_count, 2'd0);
        take_resp();
        ar_wait = 0; r_wait = 0;

        // Error responses saturating a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            rresp_cfg = err_codes[i]; rdata_cfg = 32'hDEAD_0000 + i;
            exp_araddr = 32'h0000_1020;
            send_req(1'b0, 32'h20, 32'h0, 4'h0);
            wait_resp(lat);
            check_eq("err_code", resp_code, err_codes[i]);
            check_eq("err_count", err_count, err_exp[i]);
            take_resp();
        end
        rresp_cfg = 2'b00;

        // Response backpressure with a second request pending
        rdata_cfg = 32'h55AA_1234; exp_araddr = 32'h0000_1004;
        send_req(1'b0, 32'h4, 32'h0, 4'h0);
        wait_resp(lat);
        req_v = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_data = 32'h1234_5678; req_wstrb = 4'h3;
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_req_ready", req_ready, 1'b0);
            check_eq("bp_resp_v", resp_v, 1'b1);
            check_eq("bp_resp_data", resp_data, 32'h55AA_1234);
            check_eq("bp_resp_we", resp_we, 1'b0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("bp_resp_done", resp_v, 1'b0);
        check_eq("bp_ready_next", req_ready, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
        req_v = 1'b0;
        check_eq("bp_second_accepted", mo.awvalid, 1'b1);
        wait_resp(lat);
        check_eq("bp_wr_lat", lat, 3);
        check_eq("bp_wr_awaddr", last_awaddr, 32'h0000_1008);
        check_eq("bp_wr_wstrb", last_wstrb, 4'h3);
        check_eq("bp_wr_we", resp_we, 1'b1);
        check_eq("bp_wr_data", resp_data, 32'h0);
        take_resp();

        // Asynchronous reset while waiting for read data
        r_wait = 30; exp_araddr = 32'h0000_1030;
        send_req(1'b0, 32'h30, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            if (mo.rready) break;
            @(negedge clk);
        end
        check_eq("ar_reached_rd_data", mo.rready, 1'b1);
        check_eq("ar_err_before", err_count, 2'd3);
        #2 reset_n = 1'b0;
        #1;
        check_eq("ar_arvalid", mo.arvalid, 1'b0);
        check_eq("ar_rready", mo.rready, 1'b0);
        check_eq("ar_resp_v", resp_v, 1'b0);
        check_eq("ar_err", err_count, 2'd0);
        check_eq("ar_req_ready", req_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        r_wait = 0;
        @(negedge clk);
        check_eq("ar_idle_ready", req_ready, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_eq("ar_no_resp", resp_v, 1'b0);
            @(negedge clk);
        end

        // Normal operation after reset
        s_aw = n_aw;
        send_req(1'b1, 32'hFFFF_F000, 32'hA5A5_5A5A, 4'hC);
        wait_resp(lat);
        check_eq("post_wr_lat", lat, 3);
        check_eq("post_wr_awaddr_wrap", last_awaddr, 32'h0000_0000);
        check_eq("post_wr_code", resp_code, 2'b00);
        check_eq("post_wr_err", err_count, 2'd0);
        take_resp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case the DUT stalls a handshake
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bsg_fifos_to_axil.md
Name: bsg_fifos_to_axil

Overview:
- AXI-Lite master that turns a valid/ready request stream into single-beat AXI-Lite read and write transactions.
- Read data and write responses come back on a valid/ready response stream.
- It is the initiator counterpart of the FIFO-facing AXI-Lite slave adapter. Host-side or fabric logic uses it to program and poll remote AXI-Lite register spaces, such as FIFO pair vacancy, data and occupancy registers.
- One transaction is outstanding at a time. The block is strictly in-order.

Parameters:
- axil_base_addr_p, 32'h0000_0000, added modulo 2^32 to req_addr_i to form awaddr/araddr.
- err_count_width_p, 16, width of the saturating error counter.
- axil_mosi_bus_width_lp, bsg_axil_mosi_bus_width(1), localparam, packed master-to-slave bus width.
- axil_miso_bus_width_lp, bsg_axil_miso_bus_width(1), localparam, packed slave-to-master bus width.

Ports:
- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous, active-low reset
- m_axil_bus_o  out  axil_mosi_bus_width_lp  AXI-Lite master outputs (aw*, w*, bready, ar*, rready)
- m_axil_bus_i  in  axil_miso_bus_width_lp  AXI-Lite slave responses (awready, wready, b*, arready, r*)
- req_v_i  in  1  request valid
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  register address offset
- req_data_i  in  32  write data; ignored for reads
- req_wstrb_i  in  4  write byte strobes; ignored for reads
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o
- resp_v_o  out  1  response valid
- resp_we_o  out  1  echoes the type of the completed request
- resp_data_o  out  32  rdata for reads; 0 for writes
- resp_code_o  out  2  captured rresp or bresp
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i
- err_count_o  out  err_count_width_p  saturating count of responses with a non-OKAY code

Behaviour:
- Reset: asynchronous assert on falling reset_n_i, synchronous-safe deassert is the integrator's job. While reset_n_i = 0:
  - state = E_IDLE;
  - all AXI valid/ready outputs = 0 (awvalid, wvalid, bready, arvalid, rready);
  - resp_v_o = 0, req_ready_o = 0;
  - err_count_o = 0;
  - address, data and response holding registers = 0.
- Reset mid-transaction drops the transaction; no response is produced.
- States: E_IDLE, E_WR, E_WR_RESP, E_RD_ADDR, E_RD_DATA, E_RESP.
- E_IDLE:
  - req_ready_o = 1.
  - On accept, register addr = req_addr_i + axil_base_addr_p, and register data, wstrb and we.
  - Go to E_WR if we = 1, else E_RD_ADDR.
  - Outputs are registered, so the first AXI valid appears the cycle after accept.
- E_WR:
  - awvalid and wvalid are asserted together.
  - Flags aw_done_r and w_done_r are set independently on their handshakes. A valid drops the cycle after its own handshake.
  - Go to E_WR_RESP when both handshakes are done, including both in the same cycle.
  - awaddr, wdata and wstrb hold stable while the corresponding valid is high.
- E_WR_RESP: bready = 1. On bvalid, capture bresp into resp_code, set resp_data = 0, and go to E_RESP.
- E_RD_ADDR: arvalid = 1 and araddr stays stable. On arready, go to E_RD_DATA.
- E_RD_DATA: rready = 1. On rvalid, capture rdata and rresp, and go to E_RESP.
- E_RESP:
  - resp_v_o = 1, and response outputs hold stable until resp_ready_i.
  - On handshake, go to E_IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- Protection and unused fields: awprot = arprot = 3'b000.
- Minimum latency:
  - write, accept to resp_v_o: 3 cycles with zero-wait slave;
  - read, accept to resp_v_o: 3 cycles with zero-wait slave.
- Error counter: increments by 1 on entry to E_RESP when the captured code != 2'b00. It saturates at all-ones and does not wrap.
- Address arithmetic: 32-bit sum that wraps modulo 2^32; the carry is discarded.
- No timeout. A non-responding slave stalls the block indefinitely; this is by design.
- resp_ready_i held low: the block stays in E_RESP and req_ready_o stays 0, giving full backpressure.

Decomposition:
- State enum (fsm state type) belongs in a shared package alongside the AXI-Lite bus macros.
- Response code constants (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11) belong in the same shared package.
- Bus packing uses the existing declare_bsg_axil_bus_s macro.
- The saturating error counter is a natural sub-module: bsg_counter_sat_en. Everything else stays in one module.

Test Plan:
- Write with zero-wait slave: req addr 0x10, data 0xCAFE_F00D, wstrb 0xF, base 0x1000.
  - Required: aw and w handshakes with awaddr 0x1010, then the b handshake.
  - Required: resp_v_o with we = 1, code 0, data 0, 3 cycles after accept.
- Write where the slave accepts w 4 cycles before aw.
  - Required: wvalid drops after its handshake while awvalid holds.
  - Required: exactly one bready phase; response code 0.
- Read of addr 0x1C, slave returns rdata 0x0000_0003 after 5 wait cycles.
  - Required: araddr 0x101C stable throughout.
  - Required: resp_data_o = 0x3, we = 0, code 0.
- Read where the slave returns rresp 2'b10.
  - Required: resp_code_o = 2'b10 and err_count_o goes 0 to 1.
  - Required: with err_count_width_p = 2 and 5 error responses, err_count_o stays at 3.
- Backpressure: resp_ready_i = 0 for 10 cycles with a second request pending.
  - Required: resp outputs stable and req_ready_o = 0.
  - Required: the second request is accepted the cycle after the response handshake.
- Drive reset_n_i low mid E_RD_DATA.
  - Required: arvalid, rready and resp_v_o go 0 immediately, without waiting for a clock edge, and err_count_o = 0.
  - Required: after release, state is E_IDLE with req_ready_o = 1.
